// File: rtl/cl_crc_frame_checker.sv
// rtl/cl_crc_frame_checker.sv - CRC-32 frame checker: verifies and strips a trailing FCS
module cl_crc_frame_checker #(
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_crc_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_crc_err,
  output logic [CNT_W-1:0] cnt_drop
);

  typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] POLY_REF = reflect32(POLY);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY_REF) : (r >> 1);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_t      state;
  logic [2:0]  count;
  logic [7:0]  dly [4];
  logic [31:0] crc;
  logic        sop_pending;

  logic        acc;
  logic [31:0] crc_next;
  logic        good;
  logic        runt_new, abort_fill, fill_eop;
  logic        inc_good, inc_err;
  logic [1:0]  inc_drop;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  // A sop arriving mid-frame can both abort the old frame and be a 1-byte runt itself,
  // so the drop counter may advance by two on one edge.
  always_comb begin
    crc_next   = crc_byte(in_sop ? INIT : crc, in_data);
    good       = (crc_next == RESIDUE);
    runt_new   = acc && in_sop && in_eop;
    abort_fill = acc && in_sop && (state == FILL);
    fill_eop   = acc && !in_sop && in_eop && (state == FILL);
    inc_drop   = {1'b0, runt_new} + {1'b0, abort_fill} + {1'b0, fill_eop};
    inc_good   = acc && (state == PASS) && !in_sop && in_eop && good;
    inc_err    = acc && (state == PASS) && (in_sop || (in_eop && !good));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 3'd0;
      dly         <= '{default: 8'h00};
      crc         <= INIT;
      sop_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_crc_err <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (acc) begin
        crc <= crc_next;
        unique case (state)
          IDLE, FILL: begin
            if (in_sop) begin
              dly[0] <= in_data;
              count  <= in_eop ? 3'd0 : 3'd1;
              state  <= in_eop ? IDLE : FILL;
            end else if (state == FILL) begin
              dly[count[1:0]] <= in_data;
              count           <= count + 3'd1;
              if (in_eop) begin
                state <= IDLE;
                count <= 3'd0;
              end else if (count == 3'd3) begin
                state       <= PASS;
                sop_pending <= 1'b1;
              end
            end
          end
          PASS: begin
            // The oldest buffered byte leaves on every accepted byte; the newest four are FCS candidates.
            out_valid   <= 1'b1;
            out_data    <= dly[0];
            out_sop     <= sop_pending;
            sop_pending <= 1'b0;
            if (in_sop) begin
              out_eop     <= 1'b1;
              out_crc_err <= 1'b1;
              dly[0]      <= in_data;
              count       <= in_eop ? 3'd0 : 3'd1;
              state       <= in_eop ? IDLE : FILL;
            end else begin
              dly[0]      <= dly[1];
              dly[1]      <= dly[2];
              dly[2]      <= dly[3];
              dly[3]      <= in_data;
              out_eop     <= in_eop;
              out_crc_err <= in_eop && !good;
              if (in_eop) begin
                state <= IDLE;
                count <= 3'd0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_good    <= '0;
      cnt_crc_err <= '0;
      cnt_drop    <= '0;
    end else if (cnt_clr) begin
      cnt_good    <= '0;
      cnt_crc_err <= '0;
      cnt_drop    <= '0;
    end else begin
      cnt_good    <= sat_add(cnt_good, {1'b0, inc_good});
      cnt_crc_err <= sat_add(cnt_crc_err, {1'b0, inc_err});
      cnt_drop    <= sat_add(cnt_drop, inc_drop);
    end
  end

endmodule

// File: tb/tb_cl_crc_frame_checker.sv
// tb/tb_cl_crc_frame_checker.sv - scoreboard bench for cl_crc_frame_checker
module tb_cl_crc_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_crc_err;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_good;
  logic [15:0] cnt_crc_err;
  logic [15:0] cnt_drop;

  cl_crc_frame_checker dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_crc_err(out_crc_err),
    .cnt_clr(cnt_clr), .cnt_good(cnt_good), .cnt_crc_err(cnt_crc_err), .cnt_drop(cnt_drop)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  bit   mon_en = 0;
  int   good_m = 0, err_m = 0, drop_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t make_good(input bq_t p);
    bq_t r;
    logic [31:0] c;
    r = p;
    c = crc32(p);
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(c[31:24]);
    return r;
  endfunction

  function automatic logic [15:0] sat(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Monitor: pops the scoreboard on every output handshake, and checks held data while stalled.
  initial begin
    exp_t e;
    logic [10:0] held = '0;
    bit stall = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        stall = 0;
        continue;
      end
      if (stall) chk("hold_stable", 32'({out_valid, out_data, out_sop, out_eop, out_crc_err}), 32'({1'b1, held}));
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual %0h required none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_sop", 32'(out_sop), 32'(e.s));
          chk("out_eop", 32'(out_eop), 32'(e.e));
          if (e.e) chk("out_crc_err", 32'(out_crc_err), 32'(e.err));
        end
      end
      stall = out_valid && !out_ready;
      held  = {out_data, out_sop, out_eop, out_crc_err};
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (ready_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = ph[0];
        3: out_ready = (ph % 20) >= 10;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      sync();
      if (!done) begin
        n++;
        if (n > 300) begin
          chk("accept_timeout", 32'(n), 32'(0));
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Frame-level reference: closed frames >4 bytes emit all but the FCS; aborted frames of
  // k>=4 bytes emit the first k-3 bytes, the last flagged as an errored end of frame.
  task automatic run_frame(input bq_t f, input bit close);
    int n;
    exp_t e;
    logic [31:0] fcs;
    bq_t p;
    n = f.size();
    if (close) begin
      if (n <= 4) drop_m++;
      else begin
        for (int i = 0; i < n - 4; i++) p.push_back(f[i]);
        fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
        for (int i = 0; i < n - 4; i++) begin
          e.d = f[i]; e.s = (i == 0); e.e = (i == n - 5); e.err = (crc32(p) != fcs);
          exp_q.push_back(e);
        end
        if (crc32(p) != fcs) err_m++; else good_m++;
      end
    end else begin
      if (n <= 3) drop_m++;
      else begin
        for (int i = 0; i < n - 3; i++) begin
          e.d = f[i]; e.s = (i == 0); e.e = (i == n - 4); e.err = 1'b1;
          exp_q.push_back(e);
        end
        err_m++;
      end
    end
    for (int i = 0; i < n; i++) send_byte(f[i], i == 0, close && (i == n - 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_cnts();
    chk("cnt_good", 32'(cnt_good), 32'(sat(good_m)));
    chk("cnt_crc_err", 32'(cnt_crc_err), 32'(sat(err_m)));
    chk("cnt_drop", 32'(cnt_drop), 32'(sat(drop_m)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t gf, f, p;
    bit open = 0;
    gf = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_flags", 32'({out_sop, out_eop, out_crc_err, out_data}), 32'(0));
    chk("rst_cnts", 32'({cnt_good, cnt_crc_err, cnt_drop}), 32'(0));
    rst_n = 1'b1;
    mon_en = 1;
    sync();

    run_frame(gf, 1);
    wait_drain();
    chk("good_frame_cnt", 32'(cnt_good), 32'(1));
    check_cnts();

    f = gf;
    f[12] = 8'hCA;
    run_frame(f, 1);
    wait_drain();
    chk("bad_fcs_cnt", 32'(cnt_crc_err), 32'(1));
    chk("bad_fcs_good_hold", 32'(cnt_good), 32'(1));

    f = '{8'h31};
    run_frame(f, 1);
    f = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(f, 1);
    wait_drain();
    chk("runt_drop", 32'(cnt_drop), 32'(2));
    p = '{8'h31};
    run_frame(make_good(p), 1);
    wait_drain();
    check_cnts();

    ready_mode = 2;
    run_frame(gf, 1);
    wait_drain();
    ready_mode = 3;
    run_frame(gf, 1);
    wait_drain();
    ready_mode = 0;
    chk("bp_good_cnt", 32'(cnt_good), 32'(4));

    f.delete();
    for (int i = 0; i < 6; i++) f.push_back(gf[i]);
    run_frame(f, 0);
    run_frame(gf, 1);
    wait_drain();
    chk("abort_pass_err", 32'(cnt_crc_err), 32'(2));
    f = '{8'h31, 8'h32};
    run_frame(f, 0);
    run_frame(gf, 1);
    wait_drain();
    chk("abort_fill_drop", 32'(cnt_drop), 32'(3));
    chk("abort_good_cnt", 32'(cnt_good), 32'(6));

    ready_mode = 1;
    for (int it = 0; it < 60; it++) begin
      int kind, len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 14);
      if (kind == 9 && !open) begin
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        continue;
      end
      f.delete();
      p.delete();
      if (kind == 8) begin
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        run_frame(f, 0);
        open = 1;
      end else if (len <= 4) begin
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        run_frame(f, 1);
        open = 0;
      end else begin
        for (int i = 0; i < len - 4; i++) p.push_back(8'($urandom));
        f = make_good(p);
        if (kind >= 6) f[$urandom_range(0, len - 1)] ^= 8'(8'h01 << $urandom_range(0, 7));
        run_frame(f, 1);
        open = 0;
      end
    end
    if (open) run_frame(gf, 1);
    wait_drain();
    ready_mode = 0;
    sync();
    check_cnts();

    mon_en = 0;
    for (int i = 0; i < 8; i++) send_byte(gf[i], i == 0, 1'b0);
    chk("pre_reset_valid", 32'(out_valid), 32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    chk("async_rst_ready", 32'(in_ready), 32'(1));
    chk("async_rst_cnts", 32'({cnt_good, cnt_crc_err, cnt_drop}), 32'(0));
    good_m = 0; err_m = 0; drop_m = 0;
    exp_q.delete();
    sync();
    rst_n = 1'b1;
    mon_en = 1;
    sync();
    run_frame(gf, 1);
    wait_drain();
    check_cnts();

    force dut.cnt_good = 16'hFFFF;
    sync();
    release dut.cnt_good;
    good_m = 65535;
    run_frame(gf, 1);
    wait_drain();
    chk("sat_good", 32'(cnt_good), 32'h0000FFFF);

    cnt_clr = 1'b1;
    run_frame(gf, 1);
    cnt_clr = 1'b0;
    wait_drain();
    chk("clr_wins", 32'(cnt_good), 32'(0));
    good_m = 0; err_m = 0; drop_m = 0;
    check_cnts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
